// File: rtl/mips_hilo_muldiv_if.sv
// HI/LO unit command/result bundle between controller/regfile and the MULT/DIV block.
// Carries no timing of its own; all signals are sampled on the unit's clock.
// busy is the only flow control: the upstream side must hold off while busy is high.
interface mips_hilo_muldiv_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int HI_LO_SEL_WIDTH = 2
);
  logic [DATA_WIDTH-1:0]      srca;
  logic [DATA_WIDTH-1:0]      srcb;
  logic                       hi_write;
  logic                       lo_write;
  logic [HI_LO_SEL_WIDTH-1:0] hi_select;
  logic [HI_LO_SEL_WIDTH-1:0] lo_select;
  logic [DATA_WIDTH-1:0]      hi;
  logic [DATA_WIDTH-1:0]      lo;
  logic                       busy;
  logic                       done;

  // Controller / register-file side
  modport master (
    output srca, srcb, hi_write, lo_write, hi_select, lo_select,
    input  hi, lo, busy, done
  );

  // HI/LO unit side
  modport slave (
    input  srca, srcb, hi_write, lo_write, hi_select, lo_select,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mips_hilo_muldiv.sv
// Architectural HI/LO registers with iterative signed MULT/DIV and MTHI/MTLO.
// Latency: MTHI/MTLO one edge; MULT/DIV DATA_WIDTH+1 edges from command to HI/LO update.
// Backpressure: busy high while an operation is in flight; commands seen while busy are dropped.
module mips_hilo_muldiv #(
  parameter int DATA_WIDTH      = 32,
  parameter int HI_LO_SEL_WIDTH = 2
) (
  input logic               clk,
  input logic               rst,
  mips_hilo_muldiv_if.slave hl
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);

  localparam logic [HI_LO_SEL_WIDTH-1:0] SEL_SRCA = HI_LO_SEL_WIDTH'(1);
  localparam logic [HI_LO_SEL_WIDTH-1:0] SEL_DIV  = HI_LO_SEL_WIDTH'(2);
  localparam logic [HI_LO_SEL_WIDTH-1:0] SEL_MULT = HI_LO_SEL_WIDTH'(3);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e          state_q, state_d;
  logic            op_div_q, op_div_d;
  logic [W-1:0]    mag_a_q, mag_a_d;
  logic [W-1:0]    mag_b_q, mag_b_d;
  logic            sign_res_q, sign_res_d;
  logic            sign_rem_q, sign_rem_d;
  // MUL: {partial product high, multiplier shifting out / product low}
  // DIV: {partial remainder, dividend shifting out / quotient shifting in}
  logic [2*W-1:0]  acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic            done_q, done_d;

  // Operand magnitudes; the most-negative value maps to 2^(W-1), which still fits unsigned.
  logic [W-1:0] abs_a, abs_b;
  assign abs_a = hl.srca[W-1] ? (~hl.srca + W'(1)) : hl.srca;
  assign abs_b = hl.srcb[W-1] ? (~hl.srcb + W'(1)) : hl.srcb;

  // Command decode, only meaningful in IDLE.
  logic cmd_mult, cmd_div, cmd_bad, cmd_mthi, cmd_mtlo;
  assign cmd_mult = hl.hi_write && hl.lo_write &&
                    (hl.hi_select == SEL_MULT) && (hl.lo_select == SEL_MULT);
  assign cmd_div  = hl.hi_write && hl.lo_write &&
                    (hl.hi_select == SEL_DIV) && (hl.lo_select == SEL_DIV);
  // A result-type select that is not a clean MULT/DIV pairing kills the whole command.
  assign cmd_bad  = !cmd_mult && !cmd_div &&
                    (hl.hi_select[HI_LO_SEL_WIDTH-1] || hl.lo_select[HI_LO_SEL_WIDTH-1]);
  assign cmd_mthi = !cmd_bad && hl.hi_write && (hl.hi_select == SEL_SRCA);
  assign cmd_mtlo = !cmd_bad && hl.lo_write && (hl.lo_select == SEL_SRCA);

  // Shift-add step: add multiplicand when the current multiplier bit is set, then shift right.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mag_a_q} : {(W+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[W-1:1]};

  // Restoring divide step: shift in next dividend bit, subtract divisor if it fits.
  logic [W:0]     div_shift;
  logic           div_ge;
  logic [W-1:0]   div_rem;
  logic [2*W-1:0] div_next;
  assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_ge    = div_shift >= {1'b0, mag_b_q};
  assign div_rem   = W'(div_shift - {1'b0, mag_b_q});
  assign div_next  = div_ge ? {div_rem, acc_q[W-2:0], 1'b1}
                            : {div_shift[W-1:0], acc_q[W-2:0], 1'b0};

  // Sign-corrected results used in FIX.
  logic [2*W-1:0] prod_signed;
  logic [W-1:0]   quo_signed, rem_signed, dividend_signed;
  assign prod_signed     = sign_res_q ? (~acc_q + (2*W)'(1)) : acc_q;
  assign quo_signed      = sign_res_q ? (~acc_q[W-1:0] + W'(1)) : acc_q[W-1:0];
  assign rem_signed      = sign_rem_q ? (~acc_q[2*W-1:W] + W'(1)) : acc_q[2*W-1:W];
  assign dividend_signed = sign_rem_q ? (~mag_a_q + W'(1)) : mag_a_q;

  // Next-state and datapath control for the IDLE/MUL/DIV/FIX sequencer.
  always_comb begin
    state_d    = state_q;
    op_div_d   = op_div_q;
    mag_a_d    = mag_a_q;
    mag_b_d    = mag_b_q;
    sign_res_d = sign_res_q;
    sign_rem_d = sign_rem_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_mult || cmd_div) begin
          state_d    = cmd_div ? S_DIV : S_MUL;
          op_div_d   = cmd_div;
          mag_a_d    = abs_a;
          mag_b_d    = abs_b;
          sign_res_d = hl.srca[W-1] ^ hl.srcb[W-1];
          sign_rem_d = hl.srca[W-1];
          // Low half holds the operand consumed bit-by-bit: multiplier or dividend.
          acc_d      = {{W{1'b0}}, (cmd_div ? abs_a : abs_b)};
          cnt_d      = '0;
        end else begin
          if (cmd_mthi) hi_d = hl.srca;
          if (cmd_mtlo) lo_d = hl.srca;
        end
      end
      S_MUL, S_DIV: begin
        acc_d = (state_q == S_DIV) ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        cnt_d   = '0;
        if (!op_div_q) begin
          hi_d = prod_signed[2*W-1:W];
          lo_d = prod_signed[W-1:0];
        end else if (mag_b_q == '0) begin
          hi_d = dividend_signed;
          lo_d = '1;
        end else begin
          hi_d = rem_signed;
          lo_d = quo_signed;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_div_q   <= 1'b0;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      sign_res_q <= 1'b0;
      sign_rem_q <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_div_q   <= op_div_d;
      mag_a_q    <= mag_a_d;
      mag_b_q    <= mag_b_d;
      sign_res_q <= sign_res_d;
      sign_rem_q <= sign_rem_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign hl.hi   = hi_q;
  assign hl.lo   = lo_q;
  assign hl.busy = (state_q != S_IDLE);
  assign hl.done = done_q;

endmodule

// File: tb/tb_mips_hilo_muldiv.sv
// Directed self-checking bench for the HI/LO MULT/DIV unit.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// busy is honoured by the bench except where dropping of busy-time commands is exercised.
module tb_mips_hilo_muldiv;

  localparam int DW = 32;
  localparam int SW = 2;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mips_hilo_muldiv_if #(.DATA_WIDTH(DW), .HI_LO_SEL_WIDTH(SW)) hl ();

  mips_hilo_muldiv #(.DATA_WIDTH(DW), .HI_LO_SEL_WIDTH(SW)) dut (
    .clk (clk),
    .rst (rst),
    .hl  (hl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic hw, input logic lw, input logic [1:0] hs,
                       input logic [1:0] ls, input logic [31:0] a, input logic [31:0] b);
    hl.hi_write  = hw;
    hl.lo_write  = lw;
    hl.hi_select = hs;
    hl.lo_select = ls;
    hl.srca      = a;
    hl.srcb      = b;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
  endtask

  // Issue one MULT/DIV at the next edge and wait (bounded) for busy to drop.
  // Returns at the first cycle with busy low, which is the done cycle.
  task automatic do_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                       output int busy_cycles, output int done_during,
                       output logic done_now, output logic timed_out);
    logic [1:0] sel;
    sel = is_div ? 2'b10 : 2'b11;
    drive(1'b1, 1'b1, sel, sel, a, b);
    @(posedge clk); #1;
    // Operands are deliberately scrambled after acceptance.
    drive(1'b0, 1'b0, 2'b00, 2'b00, ~a, ~b);
    busy_cycles = 0;
    done_during = 0;
    while (hl.busy && busy_cycles < 100) begin
      busy_cycles++;
      if (hl.done) done_during++;
      @(posedge clk); #1;
    end
    timed_out = hl.busy;
    done_now  = hl.done;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (hl.hi !== 32'h0)   begin errors++; $display("FAIL reset_hi got=%h exp=%h", hl.hi, 32'h0); end
    checks++; if (hl.lo !== 32'h0)   begin errors++; $display("FAIL reset_lo got=%h exp=%h", hl.lo, 32'h0); end
    checks++; if (hl.busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b exp=0", hl.busy); end
    checks++; if (hl.done !== 1'b0)  begin errors++; $display("FAIL reset_done got=%b exp=0", hl.done); end
  endtask

  task automatic test_mult();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] eh [4];
    logic [31:0] el [4];
    int bc, dd;
    logic dn, to;
    va[0] = 32'h00000007; vb[0] = 32'hFFFFFFFD; eh[0] = 32'hFFFFFFFF; el[0] = 32'hFFFFFFEB;
    va[1] = 32'h80000000; vb[1] = 32'h80000000; eh[1] = 32'h40000000; el[1] = 32'h00000000;
    va[2] = 32'hFFFFFFFF; vb[2] = 32'hFFFFFFFF; eh[2] = 32'h00000000; el[2] = 32'h00000001;
    va[3] = 32'h00010000; vb[3] = 32'h00010001; eh[3] = 32'h00000001; el[3] = 32'h00010000;
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, va[i], vb[i], bc, dd, dn, to);
      checks++; if (to) begin errors++; $display("FAIL mult%0d_timeout busy never dropped", i); end
      checks++; if (bc != 33) begin errors++; $display("FAIL mult%0d_busy_cycles got=%0d exp=33", i, bc); end
      checks++; if (dd != 0) begin errors++; $display("FAIL mult%0d_done_while_busy got=%0d exp=0", i, dd); end
      checks++; if (dn !== 1'b1) begin errors++; $display("FAIL mult%0d_done got=%b exp=1", i, dn); end
      checks++; if (hl.hi !== eh[i]) begin errors++; $display("FAIL mult%0d_hi got=%h exp=%h", i, hl.hi, eh[i]); end
      checks++; if (hl.lo !== el[i]) begin errors++; $display("FAIL mult%0d_lo got=%h exp=%h", i, hl.lo, el[i]); end
      @(posedge clk); #1;
      checks++; if (hl.done !== 1'b0) begin errors++; $display("FAIL mult%0d_done_single got=%b exp=0", i, hl.done); end
    end
  endtask

  task automatic test_div();
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [31:0] eh [6];
    logic [31:0] el [6];
    int bc, dd;
    logic dn, to;
    va[0] = 32'd100;        vb[0] = 32'd7;          eh[0] = 32'd2;          el[0] = 32'd14;
    va[1] = 32'hFFFFFFF9;   vb[1] = 32'd2;          eh[1] = 32'hFFFFFFFF;   el[1] = 32'hFFFFFFFD;
    va[2] = 32'h80000000;   vb[2] = 32'hFFFFFFFF;   eh[2] = 32'h00000000;   el[2] = 32'h80000000;
    va[3] = 32'h00001234;   vb[3] = 32'h0;          eh[3] = 32'h00001234;   el[3] = 32'hFFFFFFFF;
    va[4] = 32'hFFFFFFFB;   vb[4] = 32'h0;          eh[4] = 32'hFFFFFFFB;   el[4] = 32'hFFFFFFFF;
    va[5] = 32'd17;         vb[5] = 32'hFFFFFFFB;   eh[5] = 32'd2;          el[5] = 32'hFFFFFFFD;
    for (int i = 0; i < 6; i++) begin
      do_op(1'b1, va[i], vb[i], bc, dd, dn, to);
      checks++; if (to) begin errors++; $display("FAIL div%0d_timeout busy never dropped", i); end
      checks++; if (bc != 33) begin errors++; $display("FAIL div%0d_busy_cycles got=%0d exp=33", i, bc); end
      checks++; if (dn !== 1'b1) begin errors++; $display("FAIL div%0d_done got=%b exp=1", i, dn); end
      checks++; if (hl.hi !== eh[i]) begin errors++; $display("FAIL div%0d_hi got=%h exp=%h", i, hl.hi, eh[i]); end
      checks++; if (hl.lo !== el[i]) begin errors++; $display("FAIL div%0d_lo got=%h exp=%h", i, hl.lo, el[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mthi_mtlo();
    // Both moves in the same cycle
    drive(1'b1, 1'b1, 2'b01, 2'b01, 32'hA5A5A5A5, 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    checks++; if (hl.busy !== 1'b0) begin errors++; $display("FAIL mtboth_busy got=%b exp=0", hl.busy); end
    // Both registers take srca in this cycle, so LO also reads A5A5A5A5 here.
    checks++; if (hl.hi !== 32'hA5A5A5A5) begin errors++; $display("FAIL mtboth_hi got=%h exp=%h", hl.hi, 32'hA5A5A5A5); end
    checks++; if (hl.lo !== 32'hA5A5A5A5) begin errors++; $display("FAIL mtboth_lo got=%h exp=%h", hl.lo, 32'hA5A5A5A5); end
    // MTLO alone leaves HI untouched
    drive(1'b0, 1'b1, 2'b00, 2'b01, 32'h5A5A5A5A, 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    checks++; if (hl.lo !== 32'h5A5A5A5A) begin errors++; $display("FAIL mtlo_lo got=%h exp=%h", hl.lo, 32'h5A5A5A5A); end
    checks++; if (hl.hi !== 32'hA5A5A5A5) begin errors++; $display("FAIL mtlo_hi_kept got=%h exp=%h", hl.hi, 32'hA5A5A5A5); end
    // Mismatched MULT encoding is ignored entirely
    drive(1'b1, 1'b0, 2'b11, 2'b11, 32'h11111111, 32'h2);
    @(posedge clk); #1;
    idle_inputs();
    checks++; if (hl.busy !== 1'b0) begin errors++; $display("FAIL badcmd_busy got=%b exp=0", hl.busy); end
    checks++; if (hl.hi !== 32'hA5A5A5A5) begin errors++; $display("FAIL badcmd_hi got=%h exp=%h", hl.hi, 32'hA5A5A5A5); end
    checks++; if (hl.lo !== 32'h5A5A5A5A) begin errors++; $display("FAIL badcmd_lo got=%h exp=%h", hl.lo, 32'h5A5A5A5A); end
  endtask

  task automatic test_drop_while_busy();
    int n;
    drive(1'b1, 1'b1, 2'b11, 2'b11, 32'h12345678, 32'h2);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 2'b00, 2'b01, 32'h0000DEAD, 32'h0);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 2'b10, 2'b10, 32'd100, 32'd7);
    @(posedge clk); #1;
    idle_inputs();
    n = 0;
    while (hl.busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    checks++; if (hl.busy !== 1'b0) begin errors++; $display("FAIL drop_timeout busy never dropped"); end
    checks++; if (n != 31) begin errors++; $display("FAIL drop_remaining_busy got=%0d exp=31", n); end
    checks++; if (hl.done !== 1'b1) begin errors++; $display("FAIL drop_done got=%b exp=1", hl.done); end
    checks++; if (hl.hi !== 32'h0) begin errors++; $display("FAIL drop_hi got=%h exp=%h", hl.hi, 32'h0); end
    checks++; if (hl.lo !== 32'h2468ACF0) begin errors++; $display("FAIL drop_lo got=%h exp=%h", hl.lo, 32'h2468ACF0); end
    @(posedge clk); #1;
    checks++; if (hl.busy !== 1'b0) begin errors++; $display("FAIL drop_no_restart got=%b exp=0", hl.busy); end
  endtask

  task automatic test_reset_mid_div();
    int bc, dd, dn_cnt;
    logic dn, to;
    drive(1'b1, 1'b1, 2'b10, 2'b10, 32'd100, 32'd7);
    @(posedge clk); #1;
    idle_inputs();
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (hl.hi !== 32'h0) begin errors++; $display("FAIL rstmid_hi got=%h exp=%h", hl.hi, 32'h0); end
    checks++; if (hl.lo !== 32'h0) begin errors++; $display("FAIL rstmid_lo got=%h exp=%h", hl.lo, 32'h0); end
    checks++; if (hl.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", hl.busy); end
    dn_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (hl.done) dn_cnt++;
      @(posedge clk); #1;
    end
    checks++; if (dn_cnt != 0) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=0", dn_cnt); end
    do_op(1'b0, 32'd6, 32'd7, bc, dd, dn, to);
    checks++; if (bc != 33) begin errors++; $display("FAIL rstmid_mult_cycles got=%0d exp=33", bc); end
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL rstmid_mult_done got=%b exp=1", dn); end
    checks++; if (hl.lo !== 32'd42) begin errors++; $display("FAIL rstmid_mult_lo got=%h exp=%h", hl.lo, 32'd42); end
    checks++; if (hl.hi !== 32'h0) begin errors++; $display("FAIL rstmid_mult_hi got=%h exp=%h", hl.hi, 32'h0); end
  endtask

  task automatic test_back_to_back();
    int bc, dd;
    logic dn, to;
    do_op(1'b0, 32'hFFFFFFFE, 32'd5, bc, dd, dn, to);
    checks++; if (hl.lo !== 32'hFFFFFFF6) begin errors++; $display("FAIL b2b_first_lo got=%h exp=%h", hl.lo, 32'hFFFFFFF6); end
    // Second command issued in the done cycle itself
    do_op(1'b1, 32'hFFFFFF9C, 32'd7, bc, dd, dn, to);
    checks++; if (bc != 33) begin errors++; $display("FAIL b2b_cycles got=%0d exp=33", bc); end
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL b2b_done got=%b exp=1", dn); end
    checks++; if (hl.lo !== 32'hFFFFFFF2) begin errors++; $display("FAIL b2b_lo got=%h exp=%h", hl.lo, 32'hFFFFFFF2); end
    checks++; if (hl.hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL b2b_hi got=%h exp=%h", hl.hi, 32'hFFFFFFFE); end
    @(posedge clk); #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_drop_while_busy();
    test_reset_mid_div();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
